md_control: RTL and testbench

MD_CONTROL -- requirements
Module: md_control

---
 rtl/md_control_if.sv | 25 ++
 rtl/md_control.sv | 192 +++++++++++++++++++
 tb/tb_md_control.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_control_if.sv
// Request/response bundle between an instruction pipeline and the HI/LO multiply/divide unit.
interface md_control_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [5:0]        funct;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              busy;
  logic              stall;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, funct, op_a, op_b,
    input  busy, stall, done, rdata, hi, lo
  );

  modport slave (
    input  start, funct, op_a, op_b,
    output busy, stall, done, rdata, hi, lo
  );
endinterface

// File: rtl/md_control.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Divider datapath is present only when MD_DIV_EN is defined; otherwise div/divu finish with HI/LO untouched.
module md_control #(
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  md_control_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W:0]   acc;
  logic [DATA_W-1:0] mq;
  logic [DATA_W-1:0] mcand;
  logic              op_div;
  logic              neg_q;
  logic [DATA_W-1:0] hi_r;
  logic [DATA_W-1:0] lo_r;
`ifdef MD_DIV_EN
  logic              neg_r;
  logic              dz;
  logic              dz_req;
  logic [DATA_W:0]   shl;
`endif

  logic is_mult, is_multu, is_div, is_divu;
  logic is_mfhi, is_mthi, is_mflo, is_mtlo;
  logic is_md, is_any, sgn_op, accept, skip_run;
  logic [DATA_W-1:0] mag_a, mag_b;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   step_acc;
  logic [DATA_W-1:0] step_mq;

  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v, input logic sgn);
    logic signed [DATA_W-1:0] n;
    n = -v;
    return (sgn && v[DATA_W-1]) ? $unsigned(n) : $unsigned(v);
  endfunction

  function automatic logic [2*DATA_W-1:0] fix_2w(input logic [2*DATA_W-1:0] v, input logic neg);
    return neg ? (~v + (2*DATA_W)'(1)) : v;
  endfunction

`ifdef MD_DIV_EN
  function automatic logic [DATA_W-1:0] fix_w(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? (~v + DATA_W'(1)) : v;
  endfunction
`endif

  assign is_mult  = (bus.funct == F_MULT);
  assign is_multu = (bus.funct == F_MULTU);
  assign is_div   = (bus.funct == F_DIV);
  assign is_divu  = (bus.funct == F_DIVU);
  assign is_mfhi  = (bus.funct == F_MFHI);
  assign is_mthi  = (bus.funct == F_MTHI);
  assign is_mflo  = (bus.funct == F_MFLO);
  assign is_mtlo  = (bus.funct == F_MTLO);
  assign is_md    = is_mult | is_multu | is_div | is_divu;
  assign is_any   = is_md | is_mfhi | is_mthi | is_mflo | is_mtlo;
  assign sgn_op   = is_mult | is_div;

  assign accept   = bus.start & (state == IDLE);
  assign mag_a    = mag($signed(bus.op_a), sgn_op);
  assign mag_b    = mag($signed(bus.op_b), sgn_op);

`ifdef MD_DIV_EN
  assign dz_req   = (is_div | is_divu) & (bus.op_b == '0);
  assign skip_run = dz_req;
`else
  assign skip_run = is_div | is_divu;
`endif

  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == FIX);
  assign bus.stall = bus.start & bus.busy & is_any;
  assign bus.rdata = is_mfhi ? hi_r : (is_mflo ? lo_r : '0);
  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;

  // One radix-2 iteration: multiply shifts the partial product right, divide shifts the remainder left.
  always_comb begin
    sum      = '0;
    step_acc = '0;
    step_mq  = '0;
`ifdef MD_DIV_EN
    shl      = {acc[DATA_W-1:0], mq[DATA_W-1]};
    if (op_div) begin
      if (shl >= {1'b0, mcand}) begin
        step_acc = shl - {1'b0, mcand};
        step_mq  = {mq[DATA_W-2:0], 1'b1};
      end else begin
        step_acc = shl;
        step_mq  = {mq[DATA_W-2:0], 1'b0};
      end
    end else
`endif
    begin
      sum      = mq[0] ? (acc + {1'b0, mcand}) : acc;
      step_acc = {1'b0, sum[DATA_W:1]};
      step_mq  = {sum[0], mq[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept && is_md) state_nxt = skip_run ? FIX : RUN;
      RUN:     if (cnt == CNT_W'(DATA_W-1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      acc    <= '0;
      mq     <= '0;
      mcand  <= '0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
`ifdef MD_DIV_EN
      neg_r  <= 1'b0;
      dz     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept && is_md) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= mag_b;
            op_div <= is_div | is_divu;
            neg_q  <= sgn_op & (bus.op_a[DATA_W-1] ^ bus.op_b[DATA_W-1]);
`ifdef MD_DIV_EN
            neg_r  <= sgn_op & bus.op_a[DATA_W-1];
            dz     <= dz_req;
            mq     <= dz_req ? bus.op_a : mag_a;
`else
            mq     <= mag_a;
`endif
          end else if (accept && is_mthi) begin
            hi_r <= bus.op_a;
          end else if (accept && is_mtlo) begin
            lo_r <= bus.op_a;
          end
        end
        RUN: begin
          acc <= step_acc;
          mq  <= step_mq;
          cnt <= cnt + 1'b1;
        end
        // Magnitude result is sign-corrected here; zero-divide keeps the raw dividend in mq.
        FIX: begin
          if (!op_div) begin
            {hi_r, lo_r} <= fix_2w({acc[DATA_W-1:0], mq}, neg_q);
          end
`ifdef MD_DIV_EN
          else if (dz) begin
            hi_r <= mq;
            lo_r <= '1;
          end else begin
            hi_r <= fix_w(acc[DATA_W-1:0], neg_r);
            lo_r <= fix_w(mq, neg_q);
          end
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_md_control.sv
// Directed bench for md_control: scoreboarded mult/div results, mt/mf moves, stall and reset abort.
module tb_md_control;
  localparam int W = 32;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  md_control_if #(.DATA_W(W)) bus ();
  md_control #(.DATA_W(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] cur_hi;
  logic [W-1:0] cur_lo;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    logic [63:0]  p;
    longint       sa, sbv, q, r;
    e.hi = cur_hi;
    e.lo = cur_lo;
    e.lat = 0;
    p = '0;
    case (f)
      F_MULT: begin
        sa = $signed(a);
        sbv = $signed(b);
        p = sa * sbv;
        e.hi = p[63:32];
        e.lo = p[31:0];
        e.lat = W;
      end
      F_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        e.hi = p[63:32];
        e.lo = p[31:0];
        e.lat = W;
      end
`ifdef MD_DIV_EN
      F_DIV, F_DIVU: begin
        if (b == '0) begin
          e.hi = a;
          e.lo = '1;
          e.lat = 0;
        end else begin
          if (f == F_DIV) begin
            sa = $signed(a);
            sbv = $signed(b);
          end else begin
            sa = longint'({32'b0, a});
            sbv = longint'({32'b0, b});
          end
          q = sa / sbv;
          r = sa % sbv;
          e.lo = q[31:0];
          e.hi = r[31:0];
          e.lat = W;
        end
      end
`endif
      default: ;
    endcase
    return e;
  endfunction

  task automatic do_md(input string tag, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   k;
    sb.push_back(model(f, a, b));
    bus.funct = f;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({tag, "_busy"}, bus.busy, 1);
    k = 0;
    while (bus.done !== 1'b1 && k < 3*W) begin
      if (k == 10) begin
        chk({tag, "_hold_hi"}, bus.hi, cur_hi);
        chk({tag, "_hold_lo"}, bus.lo, cur_lo);
      end
      tick();
      k++;
    end
    e = sb.pop_front();
    chk({tag, "_lat"}, k, e.lat);
    tick();
    chk({tag, "_hi"}, bus.hi, e.hi);
    chk({tag, "_lo"}, bus.lo, e.lo);
    chk({tag, "_done_off"}, bus.done, 0);
    chk({tag, "_idle"}, bus.busy, 0);
    cur_hi = e.hi;
    cur_lo = e.lo;
  endtask

  initial begin
    exp_t       e;
    int         k;
    logic       saw_done;
    logic [5:0] abort_f;

    bus.start = 1'b0;
    bus.funct = '0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    reset_n   = 1'b0;
    cur_hi    = '0;
    cur_lo    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_stall", bus.stall, 0);
    reset_n = 1'b1;

    do_md("mult_fffffffe_3", F_MULT, 32'hFFFFFFFE, 32'd3);
    chk("mult_fffffffe_3_const_hi", bus.hi, 32'hFFFFFFFF);
    chk("mult_fffffffe_3_const_lo", bus.lo, 32'hFFFFFFFA);
    do_md("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_max_const_hi", bus.hi, 32'hFFFFFFFE);
    chk("multu_max_const_lo", bus.lo, 32'h00000001);
    do_md("mult_minneg_sq", F_MULT, 32'h80000000, 32'h80000000);
    do_md("mult_neg_neg", F_MULT, 32'hFFFFFFFB, 32'hFFFFFFF9);

    bus.funct = F_MTHI;
    bus.op_a  = 32'h12345678;
    bus.start = 1'b1;
    #1;
    chk("mthi_stall", bus.stall, 0);
    tick();
    bus.start = 1'b0;
    chk("mthi_hi", bus.hi, 32'h12345678);
    chk("mthi_lo_keep", bus.lo, cur_lo);
    chk("mthi_busy", bus.busy, 0);
    chk("mthi_done", bus.done, 0);
    cur_hi = 32'h12345678;

    bus.funct = F_MTLO;
    bus.op_a  = 32'hCAFEF00D;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("mtlo_lo", bus.lo, 32'hCAFEF00D);
    chk("mtlo_hi_keep", bus.hi, cur_hi);
    cur_lo = 32'hCAFEF00D;

    bus.funct = F_MFHI;
    bus.start = 1'b1;
    #1;
    chk("mfhi_rdata", bus.rdata, cur_hi);
    chk("mfhi_stall", bus.stall, 0);
    bus.funct = F_MFLO;
    #1;
    chk("mflo_rdata", bus.rdata, cur_lo);
    tick();
    bus.funct = 6'b100000;
    #1;
    chk("other_rdata", bus.rdata, 0);
    chk("other_stall", bus.stall, 0);
    tick();
    bus.start = 1'b0;
    chk("other_busy", bus.busy, 0);
    chk("other_hi_keep", bus.hi, cur_hi);
    chk("other_lo_keep", bus.lo, cur_lo);

    do_md("div_m7_2", F_DIV, 32'hFFFFFFF9, 32'd2);
`ifdef MD_DIV_EN
    chk("div_m7_2_const_lo", bus.lo, 32'hFFFFFFFD);
    chk("div_m7_2_const_hi", bus.hi, 32'hFFFFFFFF);
`endif
    do_md("divu_7_0", F_DIVU, 32'd7, 32'd0);
`ifdef MD_DIV_EN
    chk("divu_7_0_const_lo", bus.lo, 32'hFFFFFFFF);
    chk("divu_7_0_const_hi", bus.hi, 32'd7);
`endif
    do_md("div_minneg_m1", F_DIV, 32'h80000000, 32'hFFFFFFFF);
    do_md("div_7_m2", F_DIV, 32'd7, 32'hFFFFFFFE);
    do_md("divu_big", F_DIVU, 32'hF0000064, 32'd7);
    do_md("div_m9_0", F_DIV, 32'hFFFFFFF7, 32'd0);

    // mfhi held against a running multiply until the unit frees up
    sb.push_back(model(F_MULT, 32'h00012345, 32'hFFFF0003));
    bus.funct = F_MULT;
    bus.op_a  = 32'h00012345;
    bus.op_b  = 32'hFFFF0003;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (2) tick();
    bus.funct = 6'b111111;
    bus.start = 1'b1;
    #1;
    chk("busy_unknown_stall", bus.stall, 0);
    bus.start = 1'b0;
    repeat (3) tick();
    bus.funct = F_MFHI;
    bus.start = 1'b1;
    #1;
    chk("mfhi_busy_stall", bus.stall, 1);
    k = 0;
    while (bus.stall === 1'b1 && k < 3*W) begin
      tick();
      k++;
    end
    e = sb.pop_front();
    chk("mfhi_stall_cycles", k, W + 1 - 5);
    chk("mfhi_after_stall_rdata", bus.rdata, e.hi);
    chk("mfhi_after_stall_lo", bus.lo, e.lo);
    bus.start = 1'b0;
    cur_hi = e.hi;
    cur_lo = e.lo;

`ifdef MD_DIV_EN
    abort_f = F_DIV;
`else
    abort_f = F_MULT;
`endif
    bus.funct = abort_f;
    bus.op_a  = 32'hFFFFFF9C;
    bus.op_b  = 32'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    reset_n = 1'b0;
    #1;
    chk("abort_hi", bus.hi, 0);
    chk("abort_lo", bus.lo, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    cur_hi = '0;
    cur_lo = '0;
    tick();
    reset_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    chk("abort_no_done", saw_done, 0);
    chk("abort_hi_stays", bus.hi, 0);
    do_md("post_reset_mult", F_MULT, 32'd1234567, 32'hFFFFFFA7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
